// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared types and helpers for the pipeline hazard controller.
//   - md_state_t : MUL/DIV sequencer state (IDLE, BUSY, DONE)
//   - fwd_sel_t  : execute-stage forwarding mux select
//   - FWD_*      : forwarding select encodings
//   - fwd_select : priority forwarding decision for one source operand
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } md_state_t;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_WB  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

  // The memory stage holds the younger result, so it is checked first.
  // x0 is hard-wired to zero and is never forwarded.
  function automatic fwd_sel_t fwd_select(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_muldiv_seq.sv
// muldiv_seq
//   Sequencer for a multi-cycle MUL/DIV held in the execute stage.
//   The instruction occupies execute for exactly LAT cycles: one start
//   cycle (IDLE, go pulse), LAT-2 BUSY cycles, and one DONE cycle in
//   which the result is valid and the pipeline is released.
// Ports:
//   clk_i, rst_i    : clock, synchronous active-high reset
//   mul_div_e_i     : execute instruction is MUL/DIV-class
//   is_div_e_i      : selects DIV_LAT instead of MUL_LAT (sampled in IDLE)
//   go_o            : one-cycle start pulse to the arithmetic unit (comb)
//   done_o          : result valid this cycle (registered)
//   busy_o          : sequencer not in IDLE (registered)
//   mul_stall_o     : hold the front of the pipeline (comb)
module muldiv_seq
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic mul_div_e_i,
  input  logic is_div_e_i,
  output logic go_o,
  output logic done_o,
  output logic busy_o,
  output logic mul_stall_o
);

  localparam int CNT_W = $clog2(DIV_LAT);

  md_state_t        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             done_reg;
  logic             busy_reg;
  logic             start;

  assign start       = (state_reg == ST_IDLE) && mul_div_e_i;
  assign go_o        = start;
  // The start cycle already counts as a stalled execute cycle.
  assign mul_stall_o = start || (state_reg == ST_BUSY);
  assign done_o      = done_reg;
  assign busy_o      = busy_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (mul_div_e_i) begin
            state_reg <= ST_BUSY;
            busy_reg  <= 1'b1;
            // Start + (LAT-2) BUSY cycles + DONE = LAT cycles in execute.
            cnt_reg   <= is_div_e_i ? CNT_W'(DIV_LAT - 2) : CNT_W'(MUL_LAT - 2);
          end
        end
        ST_BUSY: begin
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end
        end
        ST_DONE: begin
          // The held instruction leaves execute now; it is never restarted.
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard and multi-cycle scheduling controller for a five-stage RV32
//   pipeline: execute-stage operand forwarding, load-use stalls,
//   taken-branch flushes, and MUL/DIV sequencing.
// Ports:
//   clk_i, rst_i                  : clock, synchronous active-high reset
//   Rs1D_i, Rs2D_i                : decode source registers
//   Rs1E_i, Rs2E_i, RdE_i         : execute source/destination registers
//   RdM_i, RdW_i                  : memory/writeback destinations
//   RegWriteM_i, RegWriteW_i      : memory/writeback write enables
//   LoadE_i                       : execute instruction is a load
//   PCSrcE_i                      : taken branch / jump in execute
//   MulDivE_i, IsDivE_i           : execute is MUL/DIV; DIV selects DIV_LAT
//   ForwardAE_o, ForwardBE_o      : forwarding selects (00 RF, 10 MEM, 01 WB)
//   StallF_o, StallD_o, StallE_o  : hold PC, IF/ID, ID/EX
//   FlushD_o, FlushE_o, FlushM_o  : bubble into IF/ID, ID/EX, EX/MEM
//   MulDivGo_o, MulDivDone_o, MulDivBusy_o : MUL/DIV sequencing
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] Rs1D_i,
  input  logic [4:0] Rs2D_i,
  input  logic [4:0] Rs1E_i,
  input  logic [4:0] Rs2E_i,
  input  logic [4:0] RdE_i,
  input  logic [4:0] RdM_i,
  input  logic [4:0] RdW_i,
  input  logic       RegWriteM_i,
  input  logic       RegWriteW_i,
  input  logic       LoadE_i,
  input  logic       PCSrcE_i,
  input  logic       MulDivE_i,
  input  logic       IsDivE_i,
  output logic [1:0] ForwardAE_o,
  output logic [1:0] ForwardBE_o,
  output logic       StallF_o,
  output logic       StallD_o,
  output logic       StallE_o,
  output logic       FlushD_o,
  output logic       FlushE_o,
  output logic       FlushM_o,
  output logic       MulDivGo_o,
  output logic       MulDivDone_o,
  output logic       MulDivBusy_o
);

  // ---------------------------------------------------------------
  // Forwarding, one identical decision per execute source operand
  // ---------------------------------------------------------------
  logic [4:0] rs_e [2];
  fwd_sel_t   fwd_sel [2];

  assign rs_e[0] = Rs1E_i;
  assign rs_e[1] = Rs2E_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_sel[gi] = fwd_select(rs_e[gi], RdM_i, RegWriteM_i, RdW_i, RegWriteW_i);
    end
  endgenerate

  assign ForwardAE_o = fwd_sel[0];
  assign ForwardBE_o = fwd_sel[1];

  // ---------------------------------------------------------------
  // MUL/DIV sequencer
  // ---------------------------------------------------------------
  logic mul_stall;

  muldiv_seq #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_muldiv_seq (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .mul_div_e_i (MulDivE_i),
    .is_div_e_i  (IsDivE_i),
    .go_o        (MulDivGo_o),
    .done_o      (MulDivDone_o),
    .busy_o      (MulDivBusy_o),
    .mul_stall_o (mul_stall)
  );

  // ---------------------------------------------------------------
  // Stall / flush merging
  // ---------------------------------------------------------------
  logic lw_match;
  logic lw_stall;
  logic front_hold;

  assign lw_match = LoadE_i && (RdE_i != 5'd0) &&
                    ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

  // While a MUL/DIV holds ID/EX, the execute instruction is not a load
  // that could advance, so the load-use check is meaningless.
  assign lw_stall = lw_match && !mul_stall;

  // A taken branch squashes the decode instruction anyway, so stalling
  // it for a load-use hazard would only waste a cycle.
  assign front_hold = mul_stall || (lw_stall && !PCSrcE_i);

  assign StallF_o = front_hold;
  assign StallD_o = front_hold;
  assign StallE_o = mul_stall;
  assign FlushD_o = PCSrcE_i;
  assign FlushE_o = !mul_stall && (lw_stall || PCSrcE_i);
  assign FlushM_o = mul_stall;

endmodule
